// File: rtl/synth_pkg.sv
// Shared constants for the voice bank datapath: sizes, command field positions
// and the top-octave increment table used by the note-to-increment mapping.
package synth_pkg;

    localparam int NUM_BANKS  = 16;
    localparam int IDX_W      = 4;
    localparam int PHASE_W    = 24;
    localparam int OUT_W      = 24;
    localparam int NOTE_W     = 7;
    localparam int CMD_W      = 16;
    localparam int CMD_ON_BIT = 15;
    localparam int NOTE_MSB   = 14;
    localparam int NOTE_LSB   = 8;

    // Increments for notes 120..131 at a 48 kHz per-voice rate; lower octaves shift right.
    function automatic logic [PHASE_W-1:0] base_inc(input logic [3:0] semi);
        logic [PHASE_W-1:0] v;
        case (semi)
            4'd0:    v = 24'd2926232;
            4'd1:    v = 24'd3100235;
            4'd2:    v = 24'd3284585;
            4'd3:    v = 24'd3479896;
            4'd4:    v = 24'd3686822;
            4'd5:    v = 24'd3906052;
            4'd6:    v = 24'd4138318;
            4'd7:    v = 24'd4384395;
            4'd8:    v = 24'd4645104;
            4'd9:    v = 24'd4921317;
            4'd10:   v = 24'd5213953;
            4'd11:   v = 24'd5523991;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/voice_bank_manager_note_to_inc.sv
// Combinational note -> phase increment: split the note into octave and
// semitone with a compare ladder, look up the top-octave value and shift down.
module note_to_inc
    import synth_pkg::*;
(
    input  logic [NOTE_W-1:0]  i_note,
    output logic [PHASE_W-1:0] o_inc
);

    logic [3:0]        w_oct;
    logic [NOTE_W-1:0] w_oct_base;
    logic [3:0]        w_semi;

    always_comb begin
        w_oct = 4'd0;
        for (int o = 1; o <= 10; o++) begin
            if (i_note >= NOTE_W'(12 * o)) begin
                w_oct = 4'(o);
            end
        end
        w_oct_base = NOTE_W'(w_oct) * NOTE_W'(12);
        w_semi     = 4'(i_note - w_oct_base);
        o_inc      = base_inc(w_semi) >> (4'd10 - w_oct);
    end

endmodule

// File: rtl/voice_bank_manager.sv
// Polyphonic voice allocator: edge-detected note commands claim or free one of
// the sawtooth banks, and a round-robin scan emits one sample per enabled cycle.
module voice_bank_manager
    import synth_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clk_en,
    input  logic [CMD_W-1:0]     i_data,
    output logic [OUT_W-1:0]     o_signal,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid,
    output logic [NUM_BANKS-1:0] o_active
);

    logic [CMD_W-1:0]     r_prev_data;
    logic [NOTE_W-1:0]    r_note  [NUM_BANKS];
    logic [PHASE_W-1:0]   r_phase [NUM_BANKS];
    logic [PHASE_W-1:0]   r_inc   [NUM_BANKS];
    logic [NUM_BANKS-1:0] r_active;
    logic [IDX_W-1:0]     r_scan;

    logic                 w_stb;
    logic                 w_on;
    logic [NOTE_W-1:0]    w_note;
    logic [PHASE_W-1:0]   w_new_inc;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_hit_idx;
    logic                 w_free_any;
    logic [IDX_W-1:0]     w_free_idx;

    assign w_stb  = (i_data != '0) && (i_data != r_prev_data);
    assign w_on   = i_data[CMD_ON_BIT];
    assign w_note = i_data[NOTE_MSB:NOTE_LSB];

    note_to_inc u_note_to_inc (
        .i_note (w_note),
        .o_inc  (w_new_inc)
    );

    // Descending sweep so the lowest matching / free index is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (r_active[b] && (r_note[b] == w_note)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(b);
            end
            if (!r_active[b]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(b);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev_data <= '0;
            r_active    <= '0;
            r_scan      <= '0;
            o_signal    <= '0;
            o_idx       <= '0;
            o_valid     <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_note[b]  <= '0;
                r_phase[b] <= '0;
                r_inc[b]   <= '0;
            end
        end else begin
            r_prev_data <= i_data;
            o_valid     <= clk_en;
            if (clk_en) begin
                o_signal <= r_active[r_scan] ?
                            {~r_phase[r_scan][PHASE_W-1], r_phase[r_scan][PHASE_W-2:0]} : '0;
                o_idx    <= r_scan;
                r_scan   <= r_scan + 1'b1;
                if (r_active[r_scan]) begin
                    r_phase[r_scan] <= r_phase[r_scan] + r_inc[r_scan];
                end
            end
            // Placed after the accumulate so a command on the scanned bank wins.
            if (w_stb) begin
                if (w_on) begin
                    if (w_hit) begin
                        r_phase[w_hit_idx] <= '0;
                    end else if (w_free_any) begin
                        r_note[w_free_idx]   <= w_note;
                        r_phase[w_free_idx]  <= '0;
                        r_inc[w_free_idx]    <= w_new_inc;
                        r_active[w_free_idx] <= 1'b1;
                    end
                end else if (w_hit) begin
                    r_active[w_hit_idx] <= 1'b0;
                    r_phase[w_hit_idx]  <= '0;
                end
            end
        end
    end

    assign o_active = r_active;

endmodule

// File: tb/tb_voice_bank_manager.sv
// Self-checking bench for voice_bank_manager against a behavioural voice-pool model.
module tb_voice_bank_manager;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] i_data = '0;
  logic [23:0] o_signal;
  logic [3:0]  o_idx;
  logic        o_valid;
  logic [15:0] o_active;

  int checks = 0;
  int errors = 0;

  voice_bank_manager dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .clk_en   (clk_en),
    .i_data   (i_data),
    .o_signal (o_signal),
    .o_idx    (o_idx),
    .o_valid  (o_valid),
    .o_active (o_active)
  );

  always #5 clk = ~clk;

  // reference model state
  int          base_tab [12];
  logic [6:0]  m_note   [16];
  logic [23:0] m_phase  [16];
  logic [23:0] m_inc    [16];
  logic [15:0] m_active;
  int          m_scan;
  logic [23:0] m_sig;
  logic [3:0]  m_idx;
  logic        m_valid;
  logic [15:0] m_prev;

  task automatic build_table();
    for (int k = 0; k < 12; k++) begin
      real f;
      f = 440.0 * (2.0 ** ((120.0 + k - 69.0) / 12.0));
      base_tab[k] = $rtoi($floor(f * 16777216.0 / 48000.0 + 0.5));
    end
  endtask

  function automatic logic [23:0] ref_inc(int n);
    return 24'(base_tab[n % 12] >> (10 - n / 12));
  endfunction

  function automatic int find_note(logic [6:0] n);
    for (int b = 0; b < 16; b++)
      if (m_active[b] && m_note[b] == n) return b;
    return -1;
  endfunction

  function automatic int lowest_free();
    for (int b = 0; b < 16; b++)
      if (!m_active[b]) return b;
    return -1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 16; b++) begin
      m_note[b] = '0; m_phase[b] = '0; m_inc[b] = '0;
    end
    m_active = '0; m_scan = 0; m_sig = '0; m_idx = '0; m_valid = 1'b0; m_prev = '0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; i_data = '0; clk_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
  endtask

  // Drive one clock with the given command/enable and advance the model.
  task automatic cycle(input logic [15:0] data, input logic en);
    logic stb;
    int b;
    logic [6:0] n;
    stb = (data != 16'h0) && (data != m_prev);
    m_prev = data;
    if (en) begin
      m_valid = 1'b1;
      m_idx = 4'(m_scan);
      m_sig = m_active[m_scan] ? (m_phase[m_scan] - 24'h800000) : 24'h0;
      if (m_active[m_scan]) m_phase[m_scan] = m_phase[m_scan] + m_inc[m_scan];
      m_scan = (m_scan + 1) % 16;
    end else begin
      m_valid = 1'b0;
    end
    if (stb) begin
      n = data[14:8];
      b = find_note(n);
      if (data[15]) begin
        if (b >= 0) begin
          m_phase[b] = '0;
        end else begin
          b = lowest_free();
          if (b >= 0) begin
            m_note[b] = n; m_phase[b] = '0; m_inc[b] = ref_inc(int'(n)); m_active[b] = 1'b1;
          end
        end
      end else if (b >= 0) begin
        m_active[b] = 1'b0; m_phase[b] = '0;
      end
    end
    i_data = data; clk_en = en;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_signal !== 24'h0 || o_idx !== 4'h0 || o_valid !== 1'b0 || o_active !== 16'h0) begin
      errors++;
      $display("FAIL reset: sig=%h idx=%0d valid=%b active=%h, want all zero", o_signal, o_idx, o_valid, o_active);
    end
  endtask

  task automatic test_idle_scan();
    for (int k = 0; k < 16; k++) begin
      cycle(16'h0, 1'b1);
      checks++;
      if (o_idx !== 4'(k) || o_valid !== 1'b1 || o_signal !== 24'h0 || o_active !== 16'h0) begin
        errors++;
        $display("FAIL idle_scan[%0d]: idx=%0d valid=%b sig=%h active=%h, want idx=%0d valid=1 sig=0 active=0",
                 k, o_idx, o_valid, o_signal, o_active, k);
      end
    end
  endtask

  task automatic test_single_note();
    logic [23:0] prev_s;
    logic [23:0] delta;
    int nsamp;
    logic saw_wrap;
    do_reset();
    cycle(16'hC500, 1'b1);
    nsamp = 0; saw_wrap = 1'b0; prev_s = '0;
    for (int c = 0; c < 1800; c++) begin
      cycle(16'h0, 1'b1);
      checks++;
      if (o_signal !== m_sig || o_idx !== m_idx || o_valid !== m_valid) begin
        errors++;
        $display("FAIL single_note: sig=%h idx=%0d valid=%b, want sig=%h idx=%0d valid=%b",
                 o_signal, o_idx, o_valid, m_sig, m_idx, m_valid);
      end
      if (o_idx == 4'd0) begin
        if (nsamp == 0) begin
          checks++;
          if (o_signal !== 24'h800000) begin
            errors++;
            $display("FAIL first_sample: sig=%h, want 800000", o_signal);
          end
        end else begin
          delta = o_signal - prev_s;
          checks++;
          if (delta !== 24'd153791) begin
            errors++;
            $display("FAIL sample_step: delta=%0d, want 153791", delta);
          end
          if ($signed(prev_s) > $signed(o_signal)) saw_wrap = 1'b1;
        end
        prev_s = o_signal;
        nsamp++;
      end
    end
    checks++;
    if (saw_wrap !== 1'b1 || o_active !== 16'h0001) begin
      errors++;
      $display("FAIL single_note_end: wrap=%b active=%h, want wrap=1 active=0001", saw_wrap, o_active);
    end
  endtask

  task automatic test_full_pool();
    do_reset();
    for (int n = 60; n < 76; n++) begin
      cycle({1'b1, 7'(n), 8'h40}, 1'b1);
      cycle(16'h0, 1'b1);
    end
    checks++;
    if (o_active !== 16'hFFFF) begin
      errors++;
      $display("FAIL full_pool: active=%h, want FFFF", o_active);
    end
    cycle(16'hCC40, 1'b1);
    cycle(16'h0, 1'b1);
    checks++;
    if (o_active !== 16'hFFFF || o_active !== m_active) begin
      errors++;
      $display("FAIL drop_note76: active=%h, want FFFF", o_active);
    end
    cycle(16'h4500, 1'b1);
    cycle(16'h0, 1'b1);
    checks++;
    if (o_active !== 16'hFDFF) begin
      errors++;
      $display("FAIL off_69: active=%h, want FDFF", o_active);
    end
    for (int c = 0; c < 32; c++) begin
      cycle(16'h0, 1'b1);
      checks++;
      if (o_signal !== m_sig || o_idx !== m_idx || o_active !== m_active) begin
        errors++;
        $display("FAIL full_scan: sig=%h idx=%0d active=%h, want sig=%h idx=%0d active=%h",
                 o_signal, o_idx, o_active, m_sig, m_idx, m_active);
      end
    end
  endtask

  task automatic test_hold_retrigger();
    logic seen;
    do_reset();
    for (int c = 0; c < 3; c++) cycle(16'h0, 1'b1);
    for (int c = 0; c < 5; c++) cycle(16'hA800, 1'b1);
    checks++;
    if (o_active !== 16'h0001) begin
      errors++;
      $display("FAIL hold_once: active=%h, want 0001", o_active);
    end
    for (int c = 0; c < 40; c++) begin
      cycle(16'h0, 1'b1);
      checks++;
      if (o_signal !== m_sig || o_idx !== m_idx) begin
        errors++;
        $display("FAIL hold_scan: sig=%h idx=%0d, want sig=%h idx=%0d", o_signal, o_idx, m_sig, m_idx);
      end
    end
    cycle(16'hA800, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle(16'h0, 1'b1);
      checks++;
      if (o_signal !== m_sig) begin
        errors++;
        $display("FAIL retrig_scan: sig=%h, want %h", o_signal, m_sig);
      end
      if (o_idx == 4'd0 && !seen) begin
        seen = 1'b1;
        checks++;
        if (o_signal !== 24'h800000) begin
          errors++;
          $display("FAIL retrig_phase0: sig=%h, want 800000", o_signal);
        end
      end
    end
    checks++;
    if (o_active !== 16'h0001) begin
      errors++;
      $display("FAIL retrig_bank: active=%h, want 0001", o_active);
    end
  endtask

  task automatic test_clk_en();
    logic [3:0]  s_idx;
    logic [23:0] s_sig;
    do_reset();
    cycle(16'hC500, 1'b1);
    for (int c = 0; c < 21; c++) cycle(16'h0, 1'b1);
    s_idx = o_idx; s_sig = o_signal;
    for (int c = 0; c < 10; c++) begin
      cycle(16'h0, 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_idx !== s_idx || o_signal !== s_sig) begin
        errors++;
        $display("FAIL clk_en_hold: valid=%b idx=%0d sig=%h, want valid=0 idx=%0d sig=%h",
                 o_valid, o_idx, o_signal, s_idx, s_sig);
      end
    end
    cycle(16'h0, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_idx !== s_idx + 4'd1 || o_signal !== m_sig) begin
      errors++;
      $display("FAIL clk_en_resume: valid=%b idx=%0d sig=%h, want valid=1 idx=%0d sig=%h",
               o_valid, o_idx, o_signal, s_idx + 4'd1, m_sig);
    end
  endtask

  task automatic test_random();
    logic [15:0] data;
    logic en;
    int r, b;
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      r = $urandom_range(0, 9);
      if (r < 4) data = 16'h0;
      else if (r < 5) data = m_prev;
      else if (r < 8) data = {1'b1, 7'($urandom_range(1, 127)), 8'($urandom_range(0, 255))};
      else begin
        b = $urandom_range(0, 15);
        if (m_active[b] && $urandom_range(0, 1) == 1)
          data = {1'b0, m_note[b], 8'($urandom_range(0, 255))};
        else
          data = {1'b0, 7'($urandom_range(1, 127)), 8'($urandom_range(0, 255))};
      end
      en = ($urandom_range(0, 3) != 0);
      cycle(data, en);
      checks++;
      if (o_signal !== m_sig || o_idx !== m_idx || o_valid !== m_valid || o_active !== m_active) begin
        errors++;
        $display("FAIL random[%0d]: sig=%h idx=%0d valid=%b active=%h, want sig=%h idx=%0d valid=%b active=%h",
                 c, o_signal, o_idx, o_valid, o_active, m_sig, m_idx, m_valid, m_active);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(16'hBC00, 1'b1);
    cycle(16'hC000, 1'b1);
    for (int c = 0; c < 21; c++) cycle(16'h0, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (o_active !== 16'h0 || o_signal !== 24'h0 || o_valid !== 1'b0 || o_idx !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: active=%h sig=%h valid=%b idx=%0d, want all zero",
               o_active, o_signal, o_valid, o_idx);
    end
    i_data = '0; clk_en = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
    for (int c = 0; c < 16; c++) begin
      cycle(16'h0, 1'b1);
      checks++;
      if (o_active !== 16'h0 || o_signal !== 24'h0 || o_idx !== 4'(c)) begin
        errors++;
        $display("FAIL post_reset[%0d]: active=%h sig=%h idx=%0d, want 0 0 %0d", c, o_active, o_signal, o_idx, c);
      end
    end
  endtask

  initial begin
    build_table();
    model_reset();
    test_reset();
    test_idle_scan();
    test_single_note();
    test_full_pool();
    test_hold_retrigger();
    test_clk_en();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
